divider: RTL
============

DIVIDER -- requirements
Module: divider

Interface
REQ-001 Ports SHALL be, in order: CLK, rst, div, stall, A, B, divRes.
REQ-002 One clock; reset is asynchronous and active-high. CLK, input, 1: sole clock, all state updates on rising edge.
REQ-003 rst, input, 1: asynchronous, active-high reset.
REQ-004 div, input, 1: divide request, held high by the requester until stall is low.
REQ-005 stall, output, 1: high while a requested division is not yet complete.
REQ-006 A, input, 32: signed dividend, two's complement.
REQ-007 B, input, 32: signed divisor, two's complement.
REQ-008 divRes, output, 64: {remainder[63:32], quotient[31:0]}, both registered.

Function
REQ-009 States SHALL be IDLE, RUN, FIX, DONE; 5-bit iteration counter in RUN.
REQ-010 IDLE: if div=1, capture |A|, |B|, sign(A), sign(B) and B==0 flag, clear partial remainder, counter=0 -> RUN; else stay IDLE.
REQ-011 RUN: one restoring step per cycle (shift remainder left, bring in next dividend MSB, subtract |B| if no borrow, quotient bit = no-borrow); after 32 steps -> FIX.
REQ-012 FIX: apply sign/floor correction and load divRes -> DONE.
REQ-013 DONE: stall=0 for exactly one cycle; next state IDLE regardless of div, so div held high starts a new division in the following cycle.
REQ-014 stall SHALL equal div AND (state != DONE), combinationally.
REQ-015 Latency: a request seen in IDLE at cycle 0 gives stall=1 in cycles 0..33, stall=0 and valid divRes in cycle 34.
REQ-016 div=0 in RUN or FIX SHALL abort: next state IDLE, divRes unchanged.
REQ-017 Operands SHALL be sampled only in IDLE; A/B changes afterwards have no effect.
REQ-018 Result semantics: floor division, q = floor(A/B), r = A - q*B, r has the sign of B (or is zero), |r| < |B|.
REQ-019 Correction (qm, rm = magnitude results): same signs: q=qm, r=+rm if B>0 else -rm.
REQ-020 Differing signs, rm=0: q=-qm, r=0.
REQ-021 Differing signs, rm!=0: q=-qm-1, r=B-rm if B>0, r=B+rm if B<0.
REQ-022 B=0: quotient SHALL be 32'hFFFFFFFF and remainder SHALL be A; same latency, no error signal.
REQ-023 A=32'h80000000, B=-1: quotient wraps to 32'h80000000, remainder 0.
REQ-024 divRes SHALL hold its value between FIX loads, including through aborts.

Reset
REQ-025 rst=1 SHALL force state IDLE, counter 0, divRes 0, internal registers 0, asynchronously.
REQ-026 stall SHALL follow REQ-014 during reset (IDLE, so stall=div).
REQ-027 rst asserted mid-RUN discards the operation; after release with div=1 a fresh 35-cycle division begins.

Structure
REQ-028 Shared include file SHALL hold DATA_WIDTH=32 and the four state encodings; the multiplier and divider both use DATA_WIDTH.
REQ-029 Single module, no sub-module; iteration step is inline combinational logic.
REQ-030 Target 120-250 lines of RTL; no multiplier or divide operators inferred.

Verification
REQ-031 A=7, B=2, div held -> stall low at cycle 34, divRes={32'd1, 32'd3}.
REQ-032 A=-7, B=2 -> quotient 32'hFFFFFFFC, remainder 1; A=7, B=-2 -> quotient 32'hFFFFFFFC, remainder 32'hFFFFFFFF; A=-7, B=-2 -> quotient 3, remainder 32'hFFFFFFFF.
REQ-033 A=100, B=0 -> quotient 32'hFFFFFFFF, remainder 100; A=32'h80000000, B=-1 -> quotient 32'h80000000, remainder 0.
REQ-034 div held high across two divisions (A=9/B=3, then A=10/B=4) -> stall low at cycles 34 and 69, results {0,3} then {2,2}.
REQ-035 div dropped at cycle 10 -> IDLE at cycle 11, divRes unchanged; rst pulse at cycle 20 of a run -> divRes=0, stall=div immediately.
REQ-036 Random signed operands (10k) checked against a floor-division model, including B=+/-1, A=0, and |A|<|B|.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared width and state encodings for the arithmetic units.
package divider_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] mag(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? -x : x;
  endfunction

endpackage

// File: rtl/divider.sv
// Signed floor divider: 32-step restoring divide on magnitudes, then sign/floor fix-up.
// Latency 35 cycles from request to result; stall = div && !DONE, div low aborts.
module divider
  import divider_pkg::*;
(
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    div,
  output logic                    stall,
  input  logic [DATA_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   B,
  output logic [2*DATA_WIDTH-1:0] divRes
);

  localparam int W = DATA_WIDTH;

  state_t         state;
  logic [4:0]     cnt;
  logic [W-1:0]   dvd;     // dividend bits shift out, quotient bits shift in
  logic [W-1:0]   rem;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   absb;
  logic           sa;
  logic           sb;
  logic           bz;

  logic [W:0]     shifted;
  logic [W+1:0]   diff;
  logic           nob;
  logic [W-1:0]   q_fix;
  logic [W-1:0]   r_fix;

  assign stall = div && (state != DONE);

  always_comb begin
    shifted = {rem, dvd[W-1]};
    diff    = {1'b0, shifted} - {2'b00, absb};
    nob     = ~diff[W+1];
  end

  // Floor correction: remainder takes the divisor's sign.
  always_comb begin
    q_fix = dvd;
    r_fix = rem;
    if (bz) begin
      q_fix = '1;
      r_fix = a_reg;
    end else if (sa == sb) begin
      q_fix = dvd;
      r_fix = sb ? -rem : rem;
    end else if (rem == '0) begin
      q_fix = -dvd;
      r_fix = '0;
    end else begin
      q_fix = ~dvd;
      r_fix = sb ? (rem - absb) : (absb - rem);
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      dvd    <= '0;
      rem    <= '0;
      a_reg  <= '0;
      absb   <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      bz     <= 1'b0;
      divRes <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div) begin
            a_reg <= A;
            dvd   <= mag(A);
            absb  <= mag(B);
            sa    <= A[W-1];
            sb    <= B[W-1];
            bz    <= (B == '0);
            rem   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (!div) begin
            state <= IDLE;
          end else begin
            rem   <= nob ? diff[W-1:0] : shifted[W-1:0];
            dvd   <= {dvd[W-2:0], nob};
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd31) state <= FIX;
          end
        end
        FIX: begin
          if (!div) begin
            state <= IDLE;
          end else begin
            divRes <= {r_fix, q_fix};
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
